// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample transmitter: state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_LEN_W  = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } fir_state_e;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock sample FIFO with explicit occupancy counter and free-running wrapping pointers.
// Latency: a push is visible at the read side on the next cycle; read data is combinational.
// Backpressure: push ignored when full (even with a same-cycle pop); pop ignored when empty.
module fir_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32
) (
  input  logic                    aclk,
  input  logic                    rst_ni,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_dat,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_dat,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic                  w_push;
  logic                  w_pop;

  assign full    = (r_level == LVL_FULL);
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign pop_dat = r_mem[r_rd_ptr];
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap on their own width; occupancy counter decides full/empty.
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_tx.sv
// AXI-Stream framer feeding FIR samples: FIFO + one output register, tlast every len_q beats.
// Latency: write in cycle N -> tvalid in cycle N+2 while streaming; one bubble after each tlast.
// Backpressure: tdata/tlast held until tready; wr_ready_o drops when FIFO full. FIR_TX_UNDERRUN_EN adds a starvation counter.
module fir_sample_tx
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_W,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_WIDTH  = FIR_LEN_W
) (
  input  logic                          aclk,
  input  logic                          rst_ni,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [LEN_WIDTH-1:0]          frame_len_i,
  input  logic                          enable_i,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [15:0]                   underrun_cnt_o
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  fir_state_e             r_state;
  fir_state_e             w_state_nxt;
  logic                   w_latch_len;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_beat_cnt;
  logic [LEN_WIDTH-1:0]   w_len_in;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic [DATA_WIDTH-1:0]  r_tdata;
  logic                   r_rst_done;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [DATA_WIDTH-1:0]  w_fifo_dat;
  logic                   w_hs;
  logic                   w_last_hs;
  logic                   w_out_free;
  logic                   w_last_pending;
  logic                   w_load;
  logic                   w_beat_last;

  fir_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .aclk     (aclk),
    .rst_ni   (rst_ni),
    .push     (wr_valid_i & wr_ready_o),
    .push_dat (wr_data_i),
    .pop      (w_load),
    .pop_dat  (w_fifo_dat),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty),
    .level    (fifo_level_o)
  );

  // A zero length means a single-beat frame.
  assign w_len_in       = (frame_len_i == '0) ? LEN_ONE : frame_len_i;
  assign w_hs           = r_tvalid & m_axis_tready;
  assign w_last_hs      = w_hs & r_tlast;
  assign w_out_free     = ~r_tvalid | w_hs;
  // Once the closing beat is loaded nothing else enters until it has been taken.
  assign w_last_pending = r_tvalid & r_tlast;
  assign w_load         = (r_state == ST_STREAM) & ~w_fifo_empty & w_out_free & ~w_last_pending;
  assign w_beat_last    = (r_beat_cnt == r_len - LEN_ONE);

  assign wr_ready_o    = ~w_fifo_full & r_rst_done;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy_o        = (r_state == ST_STREAM);
  assign frame_done_o  = w_last_hs;

  // Keep wr_ready_o low while reset is held, high from the first clock afterwards.
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) r_rst_done <= 1'b0;
    else         r_rst_done <= 1'b1;
  end

  // State register.
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: frames only end on the tlast handshake; enable decides whether another follows.
  always_comb begin
    w_state_nxt = r_state;
    w_latch_len = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i) begin
          w_state_nxt = ST_STREAM;
          w_latch_len = 1'b1;
        end
      end
      ST_STREAM: begin
        if (w_last_hs) begin
          w_latch_len = enable_i;
          if (!enable_i) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame length snapshot and beat counter; the counter stalls while the FIFO is starved.
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len      <= LEN_ONE;
      r_beat_cnt <= '0;
    end else begin
      if (w_latch_len) r_len <= w_len_in;
      if (w_latch_len || w_last_hs) r_beat_cnt <= '0;
      else if (w_load)              r_beat_cnt <= r_beat_cnt + LEN_ONE;
    end
  end

  // Output register: refill on load, otherwise drop valid after a handshake.
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_beat_last;
      r_tdata  <= w_fifo_dat;
    end else if (w_hs) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

`ifdef FIR_TX_UNDERRUN_EN
  logic [15:0] r_underrun_cnt;
  logic        w_starve;

  // Mid-frame: a beat could have been loaded but the FIFO had nothing to give.
  assign w_starve = (r_state == ST_STREAM) & (r_beat_cnt != '0) & w_fifo_empty
                  & w_out_free & ~w_last_pending;

  // Saturating starvation counter, cleared only by reset.
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) r_underrun_cnt <= '0;
    else if (w_starve && (r_underrun_cnt != 16'hFFFF)) r_underrun_cnt <= r_underrun_cnt + 16'd1;
  end

  assign underrun_cnt_o = r_underrun_cnt;
`else
  assign underrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fir_sample_tx.sv
// Randomized scoreboard bench for fir_sample_tx: a frame-level model predicts data, tlast and done.
// Latency: inputs driven 1 time unit after the rising edge, outputs observed on the falling edge.
// Backpressure: tready patterns and a full-FIFO stall are exercised.
module tb_fir_sample_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int LENW  = 16;

  logic                     aclk = 1'b0;
  logic                     rst_ni;
  logic [DW-1:0]            wr_data;
  logic                     wr_valid;
  logic                     wr_ready_o;
  logic [LENW-1:0]          frame_len;
  logic                     enable;
  logic [DW-1:0]            m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic                     m_axis_tready;
  logic                     busy_o;
  logic                     frame_done_o;
  logic [$clog2(DEPTH):0]   fifo_level_o;
  logic [15:0]              underrun_cnt_o;

  fir_sample_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LENW)) dut (
    .aclk           (aclk),
    .rst_ni         (rst_ni),
    .wr_data_i      (wr_data),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready_o),
    .frame_len_i    (frame_len),
    .enable_i       (enable),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .fifo_level_o   (fifo_level_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [LENW-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  // ---------------- reference model / scoreboard (monitor side) ----------------
  logic [DW-1:0] exp_q[$];
  bit            last_log[$];
  int            cur_len, beat_idx, done_cnt, hs_cnt;
  int            first_wr_cyc, first_tv_cyc;
  bit            model_idle;
  bit            hold_vld, hold_last;
  logic [DW-1:0] hold_dat;
  bit            hs, exp_last, was_idle;
  logic [DW-1:0] exp_d;

  always @(negedge aclk) begin
    if (!rst_ni) begin
      exp_q.delete();
      last_log.delete();
      cur_len = 1; beat_idx = 0; done_cnt = 0; hs_cnt = 0;
      first_wr_cyc = -1; first_tv_cyc = -1;
      model_idle = 1'b1; hold_vld = 1'b0;
    end else begin
      was_idle = model_idle;
      check("busy", busy_o, !model_idle);
      if (hold_vld) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_tdata", m_axis_tdata, hold_dat);
        check("hold_tlast", m_axis_tlast, hold_last);
      end
      if (m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      hs = m_axis_tvalid && m_axis_tready;
      exp_last = 1'b0;
      if (hs) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", m_axis_tdata);
        end else begin
          exp_d = exp_q.pop_front();
          check("tdata", m_axis_tdata, exp_d);
        end
        exp_last = (beat_idx == cur_len - 1);
        check("tlast", m_axis_tlast, exp_last);
        last_log.push_back(m_axis_tlast);
        beat_idx++;
        if (exp_last) begin
          beat_idx = 0;
          if (enable) cur_len = len_of(frame_len);
          else        model_idle = 1'b1;
        end
      end
      check("frame_done", frame_done_o, exp_last);
      if (frame_done_o) done_cnt++;
      hold_vld  = m_axis_tvalid && !m_axis_tready;
      hold_dat  = m_axis_tdata;
      hold_last = m_axis_tlast;
      if (wr_valid && wr_ready_o) begin
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        exp_q.push_back(wr_data);
      end
      if (was_idle && enable) begin
        model_idle = 1'b0;
        cur_len    = len_of(frame_len);
        beat_idx   = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; wr_valid = 1'b0; enable = 1'b0; m_axis_tready = 1'b0;
    step(); step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic write(input logic [DW-1:0] d);
    int tries = 0;
    bit acc;
    wr_data = d; wr_valid = 1'b1;
    do begin
      acc = wr_ready_o;
      step();
      tries++;
    end while (!acc && tries < 500);
    wr_valid = 1'b0;
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL write_timeout: got wr_ready 0 expected 1 within 500 cycles");
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 3000) begin
      step();
      t++;
    end
    step(); step();
    check("drain_in_time", (t < 3000), 1);
  endtask

  task automatic start_stream(input logic [LENW-1:0] len, input logic rdy);
    frame_len = len; enable = 1'b1; m_axis_tready = rdy;
    step(); step();
  endtask

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit writes_done;
  int ones;

  initial begin
    rst_ni = 1'b0; wr_valid = 1'b0; wr_data = '0; enable = 1'b0;
    frame_len = '0; m_axis_tready = 1'b0;

    // ---- reset state ----
    #2;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_busy", busy_o, 0);
    check("rst_level", fifo_level_o, 0);
    check("rst_wr_ready", wr_ready_o, 0);
    check("rst_underrun", underrun_cnt_o, 0);
    step(); step();
    rst_ni = 1'b1;
    step();
    check("post_rst_wr_ready", wr_ready_o, 1);

    // ---- test 1: reset mid-frame ----
    start_stream(16'd4, 1'b0);
    write(16'h0A01);
    write(16'h0A02);
    begin
      int t = 0;
      while (!m_axis_tvalid && t < 50) begin step(); t++; end
      check("t1_tvalid_seen", m_axis_tvalid, 1);
    end
    rst_ni = 1'b0;
    #1;
    check("t1_tvalid", m_axis_tvalid, 0);
    check("t1_tlast", m_axis_tlast, 0);
    check("t1_busy", busy_o, 0);
    check("t1_level", fifo_level_o, 0);
    check("t1_done", frame_done_o, 0);
    step();
    rst_ni = 1'b1; enable = 1'b0;
    step();
    check("t1_wr_ready", wr_ready_o, 1);

    // ---- test 2: basic 4-beat frame ----
    do_reset();
    start_stream(16'd4, 1'b1);
    for (int i = 1; i <= 4; i++) write(DW'(i));
    wait_drain();
    check("t2_latency", first_tv_cyc - first_wr_cyc, 2);
    check("t2_beats", hs_cnt, 4);
    check("t2_done", done_cnt, 1);
    check("t2_only_last", {last_log[0], last_log[1], last_log[2], last_log[3]}, 4'b0001);

    // ---- test 3: back-pressure 1,0,0,1 over 64 random beats ----
    do_reset();
    start_stream(16'd8, 1'b1);
    writes_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          repeat ($urandom_range(0, 2)) step();
          write(DW'($urandom));
        end
        writes_done = 1'b1;
      end
      begin
        int k = 0;
        while ((!writes_done || exp_q.size() != 0 || m_axis_tvalid) && k < 5000) begin
          m_axis_tready = pat[k % 4];
          k++;
          step();
        end
        m_axis_tready = 1'b1;
      end
    join
    wait_drain();
    check("t3_beats", hs_cnt, 64);
    check("t3_done", done_cnt, 8);

    // ---- test 4: FIFO fills with tready low ----
    do_reset();
    start_stream(16'd33, 1'b0);
    for (int i = 0; i < 34; i++) begin
      wr_data = DW'($urandom); wr_valid = 1'b1;
      step();
    end
    wr_valid = 1'b0;
    check("t4_wr_ready", wr_ready_o, 0);
    check("t4_level", fifo_level_o, 32);
    check("t4_accepted", exp_q.size(), 33);
    check("t4_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    wait_drain();
    check("t4_beats", hs_cnt, 33);
    check("t4_done", done_cnt, 1);

    // ---- test 5: back-to-back frames, length 3 then 0 ----
    do_reset();
    start_stream(16'd3, 1'b1);
    frame_len = 16'd0;
    for (int i = 0; i < 4; i++) write(DW'($urandom));
    wait_drain();
    check("t5_beats", last_log.size(), 4);
    if (last_log.size() == 4)
      check("t5_last_pattern", {last_log[0], last_log[1], last_log[2], last_log[3]}, 4'b0011);
    check("t5_done", done_cnt, 2);
    check("t5_busy", busy_o, 1);

    // ---- test 6: mid-frame starvation ----
    do_reset();
    start_stream(16'd8, 1'b1);
    for (int i = 0; i < 4; i++) write(DW'($urandom));
    repeat (5) step();
    for (int i = 0; i < 4; i++) write(DW'($urandom));
    wait_drain();
`ifdef FIR_TX_UNDERRUN_EN
    check("t6_underrun", underrun_cnt_o, 5);
`else
    check("t6_underrun_tied", underrun_cnt_o, 0);
`endif
    ones = 0;
    foreach (last_log[i]) ones += int'(last_log[i]);
    check("t6_tlast_count", ones, 1);
    if (last_log.size() == 8) check("t6_tlast_beat8", last_log[7], 1);
    else check("t6_beats", last_log.size(), 8);
    check("t6_done", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
